// File: rtl/sample_stream_demux.sv
// Framed host-byte demultiplexer: parses SYNC/header/length frames from the FT245 path
// and steers payload bytes to one of N_CH channel FIFOs or into a per-channel config byte.
module sample_stream_demux #(
  parameter int          N_CH         = 2,
  parameter logic [7:0]  SYNC         = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 1280000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        ch_data,
  output logic [N_CH-1:0]   ch_valid,
  input  logic [N_CH-1:0]   ch_ready,
  output logic [8*N_CH-1:0] cfg,
  output logic [7:0]        err_count,
  output logic              frame_done,
  output logic              frame_active
);

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    HEADER  = 3'd1,
    LENGTH  = 3'd2,
    PAYLOAD = 3'd3,
    CONFIG  = 3'd4,
    DROP    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic                is_cfg_q, is_cfg_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [31:0]         idle_q, idle_d;
  logic [8*N_CH-1:0]   cfg_q, cfg_d;
  logic [7:0]          err_q, err_d;
  logic                done_q, done_d;
  logic                sel_rdy;
  logic                acc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Channel select decode; sel_q is always < N_CH while in PAYLOAD/CONFIG.
  always_comb begin
    sel_rdy  = 1'b0;
    ch_valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_q == 3'(k)) begin
        sel_rdy = ch_ready[k];
        if (state_q == PAYLOAD) ch_valid[k] = in_valid;
      end
    end
  end

  assign in_ready     = (state_q == PAYLOAD) ? sel_rdy : 1'b1;
  assign acc          = in_valid & in_ready;
  assign ch_data      = in_data;
  assign cfg          = cfg_q;
  assign err_count    = err_q;
  assign frame_done   = done_q;
  assign frame_active = (state_q != HUNT);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    is_cfg_d = is_cfg_q;
    cnt_d    = cnt_q;
    idle_d   = '0;
    cfg_d    = cfg_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (state_q != HUNT && !acc) begin
      // Host stall and channel back-pressure both land here.
      if (TIMEOUT_CLKS != 0 && idle_q == TIMEOUT_CLKS - 1) begin
        state_d = HUNT;
        err_d   = sat_inc(err_q);
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end else if (acc) begin
      unique case (state_q)
        HUNT: if (in_data == SYNC) state_d = HEADER;
        HEADER: begin
          sel_d    = in_data[2:0];
          is_cfg_d = in_data[7];
          state_d  = LENGTH;
        end
        LENGTH: begin
          cnt_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          if (32'(sel_q) >= 32'(N_CH)) begin
            state_d = DROP;
            err_d   = sat_inc(err_q);
          end else if (is_cfg_q) begin
            state_d = CONFIG;
          end else begin
            state_d = PAYLOAD;
          end
        end
        PAYLOAD, CONFIG, DROP: begin
          cnt_d = cnt_q - 9'd1;
          if (state_q == CONFIG) begin
            for (int k = 0; k < N_CH; k++)
              if (sel_q == 3'(k)) cfg_d[8*k +: 8] = in_data;
          end
          if (cnt_q == 9'd1) begin
            state_d = HUNT;
            done_d  = (state_q != DROP);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      sel_q    <= '0;
      is_cfg_q <= 1'b0;
      cnt_q    <= '0;
      idle_q   <= '0;
      cfg_q    <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      is_cfg_q <= is_cfg_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      cfg_q    <= cfg_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule
